product_accumulator: RTL

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 121 ++++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: sums FRAME_LEN unsigned 8-bit products into a saturating
// ACC_W-bit accumulator and presents one result per frame; 1-cycle result latency,
// input stalls (in_ready=0) while a result waits for out_ready.
// Ports: clk/rst (async active-high), clr (sync frame abort),
//        in_valid/in_ready/in_product (product stream),
//        out_valid/out_ready/out_sum/out_ovf (frame result, zero when not valid).
module product_accumulator #(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int                 CNT_W   = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]   LAST    = CNT_W'(FRAME_LEN);
  localparam logic [ACC_W:0]     SAT_MAX = {1'b0, {ACC_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ovf, w_ovf_nxt;
  // Low during reset and until the first edge after it, so in_ready is 0 while
  // rst is high even though the state register already reads IDLE.
  logic             r_live;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [ACC_W:0]   w_sum;
  logic             w_clip;
  logic [CNT_W-1:0] w_cnt_inc;

  assign in_ready   = r_live && (r_state != DONE);
  assign out_valid  = (r_state == DONE);
  assign out_sum    = out_valid ? r_acc : '0;
  assign out_ovf    = out_valid & r_ovf;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // One extra bit of headroom so the sum never wraps before the clip test.
  assign w_sum      = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, in_product};
  assign w_clip     = (w_sum > SAT_MAX);
  assign w_cnt_inc  = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    if (clr) begin
      // Abort wins over any coincident handshake on this edge.
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_xfer) begin
            w_acc_nxt   = {{(ACC_W-8){1'b0}}, in_product};
            w_cnt_nxt   = CNT_W'(1);
            w_ovf_nxt   = 1'b0;
            w_state_nxt = (LAST == CNT_W'(1)) ? DONE : ACC;
          end
        end
        ACC: begin
          if (w_in_xfer) begin
            w_acc_nxt = w_clip ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
            w_ovf_nxt = r_ovf | w_clip;
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == LAST) begin
              w_state_nxt = DONE;
            end
          end
        end
        DONE: begin
          if (w_out_xfer) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      r_live  <= 1'b1;
    end
  end

endmodule
